// File: rtl/esm_reorder.sv
// Reorder window: accepts tag-addressed instructions out of order and releases them in tag order.
// Defining ESM_REORDER_STATS_EN adds the drained_count / stall_cycles statistics counters.
module esm_reorder #(
    parameter int unsigned Instr_word_size = 32,
    parameter int unsigned bs              = 16,
    localparam int unsigned TW             = $clog2(bs)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [TW-1:0]              in_tag,
    input  logic [Instr_word_size-1:0] Instr_in,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [Instr_word_size-1:0] Instr_out,
    output logic [TW-1:0]              head_tag,
    output logic [TW:0]                occupancy,
    output logic [31:0]                drained_count,
    output logic [31:0]                stall_cycles
);

    localparam logic          ST_EMPTY = 1'b0;
    localparam logic          ST_FULL  = 1'b1;
    localparam logic [TW:0]   OCC_FULL = (TW+1)'(bs);

    logic [bs-1:0]              r_valid;
    logic [Instr_word_size-1:0] r_mem [bs];
    logic                       r_state;
    logic                       w_state_next;
    logic [TW-1:0]              r_head;
    logic [TW:0]                r_occ;
    logic [Instr_word_size-1:0] r_out;
    logic                       w_accept;
    logic                       w_load;

    // Slot is writable only while empty; flush blocks all writes.
    assign in_ready = !flush && !r_valid[in_tag] && (r_occ != OCC_FULL);
    assign w_accept = in_valid && in_ready;

    // Output register: load head entry when it is present and the register is free or draining.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        if (flush) begin
            w_state_next = ST_EMPTY;
        end else if (r_state == ST_EMPTY) begin
            if (r_valid[r_head]) begin
                w_load       = 1'b1;
                w_state_next = ST_FULL;
            end
        end else if (out_ready) begin
            if (r_valid[r_head]) begin
                w_load = 1'b1;
            end else begin
                w_state_next = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_valid <= '0;
            r_head  <= '0;
            r_occ   <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_next;
            if (flush) begin
                r_valid <= '0;
                r_head  <= '0;
                r_occ   <= '0;
            end else begin
                if (w_accept) begin
                    r_valid[in_tag] <= 1'b1;
                end
                if (w_load) begin
                    r_valid[r_head] <= 1'b0;
                    r_out           <= r_mem[r_head];
                    r_head          <= r_head + TW'(1);
                end
                if (w_accept && !w_load) begin
                    r_occ <= r_occ + (TW+1)'(1);
                end else if (!w_accept && w_load) begin
                    r_occ <= r_occ - (TW+1)'(1);
                end
            end
        end
    end

    // Data storage carries no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[in_tag] <= Instr_in;
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign Instr_out = r_out;
    assign head_tag  = r_head;
    assign occupancy = r_occ;

`ifdef ESM_REORDER_STATS_EN
    logic [31:0] r_drained;
    logic [31:0] r_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drained <= '0;
            r_stall   <= '0;
        end else if (flush) begin
            r_drained <= '0;
            r_stall   <= '0;
        end else if (r_state == ST_FULL) begin
            if (out_ready) begin
                r_drained <= r_drained + 32'd1;
            end else begin
                r_stall <= r_stall + 32'd1;
            end
        end
    end

    assign drained_count = r_drained;
    assign stall_cycles  = r_stall;
`else
    assign drained_count = '0;
    assign stall_cycles  = '0;
`endif

endmodule

// File: doc/esm_reorder.md
Name: esm_reorder

Overview:
- Receive-side counterpart of the ESM instruction shuffler.
- Accepts instructions that arrive out of program order, each tagged with its sequence slot.
- Holds them in a bs-entry window and releases them strictly in tag order through a valid/ready output.
- Sits between the shuffled instruction stream and the in-order retire/commit stage.

Parameters:
- Instr_word_size, 32, instruction width in bits
- bs, 16, window depth in entries; power of two, at least 2
- TW, $clog2(bs), tag width (derived; not overridden)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input instruction present
- in_ready  out  1  input accepted this cycle when in_valid && in_ready
- in_tag  in  TW  sequence slot of the input instruction, modulo bs
- Instr_in  in  Instr_word_size  input instruction word
- flush  in  1  synchronous window clear
- out_valid  out  1  Instr_out holds the next in-order instruction
- out_ready  in  1  consumer takes Instr_out when out_valid && out_ready
- Instr_out  out  Instr_word_size  in-order instruction
- head_tag  out  TW  tag of the next instruction to be released
- occupancy  out  TW+1  number of stored entries, excluding the output register
- drained_count  out  32  instructions delivered (statistics; see Optional Feature)
- stall_cycles  out  32  cycles with out_valid && !out_ready (statistics)

Behaviour:
- Reset: asynchronous on rst_n low; takes effect immediately, mid-operation included. All of the following clear: every valid bit, head_tag, occupancy, out_valid, Instr_out, and both statistics counters.
- Storage: bs data entries plus bs valid bits, indexed directly by tag.
- Input ready: in_ready = !valid[in_tag], combinational from current state.
  - Accept: writes Instr_in into slot in_tag and sets valid[in_tag] on that edge.
  - Occupied slot: in_ready = 0; the sender must hold its request.
- Output register states:
  - EMPTY (out_valid = 0) or FULL (out_valid = 1).
  - Load condition: valid[head_tag] && (EMPTY || out_ready).
  - On load: Instr_out takes the head_tag entry, valid[head_tag] clears, head_tag increments with wrap from bs-1 to 0, and out_valid becomes 1.
  - FULL && out_ready && no load: go to EMPTY.
  - FULL && !out_ready: hold Instr_out unchanged.
- Latency:
  - Instruction whose tag equals head_tag, accepted on edge k with the output register EMPTY: out_valid = 1 after edge k+1.
  - No combinational bypass from input to output.
- Throughput: one delivery per cycle while consecutive tags are present and out_ready = 1.
- Same-cycle write and drain to one slot cannot occur: draining requires valid = 1, writing requires valid = 0. A slot freed by a drain becomes writable on the following cycle.
- occupancy: +1 on accept, -1 on load, unchanged when both happen in one cycle. Range 0..bs.
- Window full (occupancy = bs): in_ready = 0 for every tag.
- Gap: a missing head_tag stalls output indefinitely; later-tag entries remain stored.
- flush: synchronous and highest priority.
  - Clears all valid bits, head_tag, occupancy, and out_valid.
  - Any accept or load in the same cycle is discarded.
  - in_ready is forced to 0 while flush = 1.
- out_valid, Instr_out, head_tag, and occupancy are all registered outputs.

Optional Feature:
- Macro: ESM_REORDER_STATS_EN.
- Defined:
  - drained_count increments on each out_valid && out_ready handshake and wraps at 2^32.
  - stall_cycles increments on each cycle with out_valid && !out_ready.
  - Both counters are cleared by rst_n and by flush.
- Undefined: counter logic is absent and both ports are tied to 0. All other behaviour is identical.

Test Plan:
- In order, out_ready = 1: tags 0,1,2,3 with Instr_in = 0xA0..0xA3 on consecutive cycles -> Instr_out = 0xA0 after the edge following the tag-0 accept, then 0xA1, 0xA2, 0xA3 on consecutive cycles; occupancy never exceeds 1.
- Reverse order: tags 3,2,1,0 (data 0xB3..0xB0) -> no out_valid until tag 0 is accepted; then 0xB0..0xB3 on 4 consecutive cycles; head_tag ends at 4.
- Full window and wrap, bs = 16:
  - Fill tags 1..15, then tag 0, with out_ready = 0 -> out_valid = 1 holding the tag-0 word, occupancy = 15.
  - A re-present of tag 1 then sees in_ready = 0 (slot 1 still occupied).
  - Release out_ready and drain all 16 in order; head_tag wraps to 0.
  - A new tag-0 write is accepted and delivered.
- Backpressure: out_ready toggled 1,0,0,1 during a 4-instruction run -> no loss or duplication; Instr_out held stable while stalled; stall_cycles = 2 with ESM_REORDER_STATS_EN.
- Flush mid-operation: tags 2,3 stored, then flush = 1 for one cycle -> occupancy = 0, head_tag = 0, out_valid = 0; a subsequent tag-0 accept is delivered normally.
- Reset mid-operation: rst_n dropped asynchronously (between edges) while out_valid = 1 -> out_valid, occupancy, and head_tag go to 0 immediately, with no clock edge needed.
